execute_stage: RTL and testbench

//  E stage of the BEAN-2 5-stage pipeline: D->E pipeline register, ALU, branch/jump

---
 rtl/bean2_pkg.sv | 37 +++
 rtl/mul_iter.sv | 111 +++++++++++
 rtl/execute_stage.sv | 187 ++++++++++++++++++
 tb/tb_execute_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bean2_pkg.sv
// rtl/bean2_pkg.sv - shared encodings for the BEAN-2 execute stage
package bean2_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] MUL_MUL    = 2'b00;
    localparam logic [1:0] MUL_MULH   = 2'b01;
    localparam logic [1:0] MUL_MULHSU = 2'b10;
    localparam logic [1:0] MUL_MULHU  = 2'b11;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative shift-add RV32M multiplier
module mul_iter
    import bean2_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_advance,
    input  logic [1:0]        i_op,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [2*XLEN-1:0] o_product
);

    localparam int              CNT_W    = $clog2(XLEN / MUL_STEP + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN / MUL_STEP);

    mul_state_e        r_state;
    mul_state_e        w_state_next;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic              r_neg;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [2*XLEN-1:0] w_sum;
    logic              w_last;

    // Operands are reduced to magnitudes; the sign is re-applied once at the end.
    assign w_a_neg = ((i_op == MUL_MULH) || (i_op == MUL_MULHSU)) && i_a[XLEN-1];
    assign w_b_neg = (i_op == MUL_MULH) && i_b[XLEN-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;
    assign w_last  = (r_cnt == CNT_W'(1));

    // Accumulate MUL_STEP shifted partial products in one cycle.
    always_comb begin
        w_sum = r_acc;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (r_mplier[i]) begin
                w_sum = w_sum + (r_mcand << i);
            end
        end
    end

    // State register; reset (including pipeline flush) aborts any run.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= MUL_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: start on a valid multiply, finish when the count runs out,
    // leave DONE only when the pipeline takes the result.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MUL_IDLE: if (i_start)   w_state_next = MUL_RUN;
            MUL_RUN:  if (w_last)    w_state_next = MUL_DONE;
            MUL_DONE: if (i_advance) w_state_next = MUL_IDLE;
            default:                 w_state_next = MUL_IDLE;
        endcase
    end

    // Datapath: latch magnitudes on start, shift-add while running, hold in DONE.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (i_start) begin
                        r_acc    <= '0;
                        r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= w_a_neg ^ w_b_neg;
                        r_cnt    <= CNT_INIT;
                    end
                end
                MUL_RUN: begin
                    r_acc    <= (w_last && r_neg) ? -w_sum : w_sum;
                    r_mcand  <= r_mcand << MUL_STEP;
                    r_mplier <= r_mplier >> MUL_STEP;
                    r_cnt    <= r_cnt - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy    = i_start && (r_state != MUL_DONE);
    assign o_done    = (r_state == MUL_DONE);
    assign o_product = r_acc;

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - BEAN-2 E stage: D->E register, ALU, branch resolution, multiplier
module execute_stage
    import bean2_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            reset_E,
    input  logic            en_E,
    input  logic            valid_D,
    input  logic [XLEN-1:0] pc_D,
    input  logic [XLEN-1:0] rs1_val_D,
    input  logic [XLEN-1:0] rs2_val_D,
    input  logic [XLEN-1:0] imm_D,
    input  logic [1:0]      src_a_sel_D,
    input  logic            src_b_imm_D,
    input  logic [3:0]      alu_op_D,
    input  logic            branch_D,
    input  logic            jal_D,
    input  logic            jalr_D,
    input  logic [2:0]      funct3_D,
    input  logic            mul_D,
    input  logic [1:0]      mul_op_D,
    input  logic [4:0]      rd_D,
    input  logic            reg_WE_D,
    output logic            valid_E,
    output logic [4:0]      rd_E,
    output logic            reg_WE_E,
    output logic [XLEN-1:0] store_data_E,
    output logic [XLEN-1:0] result_E,
    output logic            jumping,
    output logic [XLEN-1:0] jump_target,
    output logic            mul_busy
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_imm;
    logic [1:0]      r_src_a_sel;
    logic            r_src_b_imm;
    logic [3:0]      r_alu_op;
    logic            r_branch;
    logic            r_jal;
    logic            r_jalr;
    logic [2:0]      r_funct3;
    logic            r_mul;
    logic [1:0]      r_mul_op;
    logic [4:0]      r_rd;
    logic            r_reg_we;

    logic              w_capture;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic [2*XLEN-1:0] w_product;
    logic [XLEN-1:0]   w_src_a;
    logic [XLEN-1:0]   w_src_b;
    logic [4:0]        w_shamt;
    logic [XLEN-1:0]   w_alu;
    logic              w_taken;
    logic [XLEN-1:0]   w_jalr_sum;

    // A running multiply freezes the D->E register even if hazard_logic has not stalled yet.
    assign w_capture = en_E && !w_mul_busy;

    // D->E pipeline register.
    always_ff @(posedge clk or posedge reset_E) begin
        if (reset_E) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_imm       <= '0;
            r_src_a_sel <= SRC_A_RS1;
            r_src_b_imm <= 1'b0;
            r_alu_op    <= ALU_ADD;
            r_branch    <= 1'b0;
            r_jal       <= 1'b0;
            r_jalr      <= 1'b0;
            r_funct3    <= '0;
            r_mul       <= 1'b0;
            r_mul_op    <= MUL_MUL;
            r_rd        <= '0;
            r_reg_we    <= 1'b0;
        end else if (w_capture) begin
            r_valid     <= valid_D;
            r_pc        <= pc_D;
            r_rs1       <= rs1_val_D;
            r_rs2       <= rs2_val_D;
            r_imm       <= imm_D;
            r_src_a_sel <= src_a_sel_D;
            r_src_b_imm <= src_b_imm_D;
            r_alu_op    <= alu_op_D;
            r_branch    <= branch_D;
            r_jal       <= jal_D;
            r_jalr      <= jalr_D;
            r_funct3    <= funct3_D;
            r_mul       <= mul_D;
            r_mul_op    <= mul_op_D;
            r_rd        <= rd_D;
            r_reg_we    <= reg_WE_D;
        end
    end

    // Operand selection and ALU.
    always_comb begin
        case (r_src_a_sel)
            SRC_A_RS1:  w_src_a = r_rs1;
            SRC_A_PC:   w_src_a = r_pc;
            SRC_A_ZERO: w_src_a = '0;
            default:    w_src_a = '0;
        endcase
        w_src_b = r_src_b_imm ? r_imm : r_rs2;
        w_shamt = w_src_b[4:0];
        case (r_alu_op)
            ALU_ADD:  w_alu = w_src_a + w_src_b;
            ALU_SUB:  w_alu = w_src_a - w_src_b;
            ALU_SLL:  w_alu = w_src_a << w_shamt;
            ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
            ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (w_src_a < w_src_b)};
            ALU_XOR:  w_alu = w_src_a ^ w_src_b;
            ALU_SRL:  w_alu = w_src_a >> w_shamt;
            ALU_SRA:  w_alu = $signed(w_src_a) >>> w_shamt;
            ALU_OR:   w_alu = w_src_a | w_src_b;
            ALU_AND:  w_alu = w_src_a & w_src_b;
            default:  w_alu = '0;
        endcase
    end

    // Branch condition on the raw register operands; unlisted funct3 codes never branch.
    always_comb begin
        case (r_funct3)
            BR_BEQ:  w_taken = (r_rs1 == r_rs2);
            BR_BNE:  w_taken = (r_rs1 != r_rs2);
            BR_BLT:  w_taken = ($signed(r_rs1) < $signed(r_rs2));
            BR_BGE:  w_taken = ($signed(r_rs1) >= $signed(r_rs2));
            BR_BLTU: w_taken = (r_rs1 < r_rs2);
            BR_BGEU: w_taken = (r_rs1 >= r_rs2);
            default: w_taken = 1'b0;
        endcase
    end

    mul_iter #(
        .XLEN     (XLEN),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk       (clk),
        .i_reset   (reset_E),
        .i_start   (r_valid && r_mul),
        .i_advance (w_capture),
        .i_op      (r_mul_op),
        .i_a       (r_rs1),
        .i_b       (r_rs2),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    // Result mux: link address, multiplier half, or ALU output.
    always_comb begin
        if (r_jal || r_jalr) begin
            result_E = r_pc + XLEN'(4);
        end else if (r_mul) begin
            if (!w_mul_done) begin
                result_E = '0;
            end else if (r_mul_op == MUL_MUL) begin
                result_E = w_product[XLEN-1:0];
            end else begin
                result_E = w_product[2*XLEN-1:XLEN];
            end
        end else begin
            result_E = w_alu;
        end
    end

    assign w_jalr_sum   = r_rs1 + r_imm;
    assign jump_target  = r_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : (r_pc + r_imm);
    assign jumping      = r_valid && (r_jal || r_jalr || (r_branch && w_taken));
    assign mul_busy     = w_mul_busy;
    assign valid_E      = r_valid;
    assign rd_E         = r_rd;
    assign reg_WE_E     = r_valid && r_reg_we;
    assign store_data_E = r_rs2;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed scoreboard bench for execute_stage
module tb_execute_stage;
    import bean2_pkg::*;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [1:0]  asel;
        logic        bimm;
        logic [3:0]  op;
        logic        br;
        logic        jal;
        logic        jalr;
        logic [2:0]  f3;
        logic        mul;
        logic [1:0]  mop;
        logic [4:0]  rd;
        logic        we;
    } instr_t;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        jmp;
        logic [31:0] tgt;
        logic        we;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_E;
    logic        en_E;
    logic        valid_D;
    logic [31:0] pc_D;
    logic [31:0] rs1_val_D;
    logic [31:0] rs2_val_D;
    logic [31:0] imm_D;
    logic [1:0]  src_a_sel_D;
    logic        src_b_imm_D;
    logic [3:0]  alu_op_D;
    logic        branch_D;
    logic        jal_D;
    logic        jalr_D;
    logic [2:0]  funct3_D;
    logic        mul_D;
    logic [1:0]  mul_op_D;
    logic [4:0]  rd_D;
    logic        reg_WE_D;
    logic        valid_E;
    logic [4:0]  rd_E;
    logic        reg_WE_E;
    logic [31:0] store_data_E;
    logic [31:0] result_E;
    logic        jumping;
    logic [31:0] jump_target;
    logic        mul_busy;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    execute_stage #(.XLEN(32), .MUL_STEP(1)) dut (
        .clk(clk), .reset_E(reset_E), .en_E(en_E), .valid_D(valid_D), .pc_D(pc_D),
        .rs1_val_D(rs1_val_D), .rs2_val_D(rs2_val_D), .imm_D(imm_D),
        .src_a_sel_D(src_a_sel_D), .src_b_imm_D(src_b_imm_D), .alu_op_D(alu_op_D),
        .branch_D(branch_D), .jal_D(jal_D), .jalr_D(jalr_D), .funct3_D(funct3_D),
        .mul_D(mul_D), .mul_op_D(mul_op_D), .rd_D(rd_D), .reg_WE_D(reg_WE_D),
        .valid_E(valid_E), .rd_E(rd_E), .reg_WE_E(reg_WE_E), .store_data_E(store_data_E),
        .result_E(result_E), .jumping(jumping), .jump_target(jump_target), .mul_busy(mul_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(input logic [3:0] op, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input logic [31:0] imm, input logic bimm);
        instr_t t;
        t.valid = 1'b1; t.pc = 32'h40; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
        t.asel = SRC_A_RS1; t.bimm = bimm; t.op = op; t.br = 1'b0; t.jal = 1'b0;
        t.jalr = 1'b0; t.f3 = 3'b000; t.mul = 1'b0; t.mop = MUL_MUL; t.rd = 5'd3; t.we = 1'b1;
        return t;
    endfunction

    task automatic drive(input instr_t t);
        valid_D = t.valid; pc_D = t.pc; rs1_val_D = t.rs1; rs2_val_D = t.rs2; imm_D = t.imm;
        src_a_sel_D = t.asel; src_b_imm_D = t.bimm; alu_op_D = t.op; branch_D = t.br;
        jal_D = t.jal; jalr_D = t.jalr; funct3_D = t.f3; mul_D = t.mul; mul_op_D = t.mop;
        rd_D = t.rd; reg_WE_D = t.we;
    endtask

    // Drive at a negedge, capture on the posedge, return at the next negedge.
    task automatic cap(input instr_t t);
        drive(t);
        en_E = 1'b1;
        @(posedge clk);
        #1 valid_D = 1'b0;
        @(negedge clk);
    endtask

    task automatic issue(input string tag, input instr_t t, input logic [31:0] res,
                         input logic jmp, input logic [31:0] tgt);
        exp_t e;
        e.tag = tag; e.res = res; e.jmp = jmp; e.tgt = tgt; e.we = t.valid & t.we; e.rd = t.rd;
        sb.push_back(e);
        cap(t);
    endtask

    task automatic retire();
        exp_t e;
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL scoreboard_empty: observed=0 expected=1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_res"}, result_E, e.res);
            check({e.tag, "_jmp"}, {31'b0, jumping}, {31'b0, e.jmp});
            check({e.tag, "_tgt"}, jump_target, e.tgt);
            check({e.tag, "_we"}, {31'b0, reg_WE_E}, {31'b0, e.we});
            check({e.tag, "_rd"}, {27'b0, rd_E}, {27'b0, e.rd});
        end
    endtask

    task automatic wait_busy(input string tag, input int exp_n);
        int n = 0;
        while (mul_busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(tag, n, exp_n);
    endtask

    initial begin
        instr_t t;
        exp_t   dropped;

        reset_E = 1'b1;
        en_E = 1'b0;
        t = mk(ALU_ADD, 32'h0, 32'h0, 32'h0, 1'b0);
        t.valid = 1'b0;
        drive(t);
        repeat (2) @(negedge clk);

        check("rst_result", result_E, 32'h0);
        check("rst_valid", {31'b0, valid_E}, 32'h0);
        check("rst_jump", {31'b0, jumping}, 32'h0);
        check("rst_busy", {31'b0, mul_busy}, 32'h0);
        check("rst_target", jump_target, 32'h0);
        check("rst_store", store_data_E, 32'h0);
        check("rst_we", {31'b0, reg_WE_E}, 32'h0);
        reset_E = 1'b0;
        @(negedge clk);

        // ALU
        issue("add_wrap", mk(ALU_ADD, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b1), 32'h0, 1'b0, 32'h41);
        retire();
        issue("sra31", mk(ALU_SRA, 32'h8000_0000, 32'h0, 32'd31, 1'b1), 32'hFFFF_FFFF, 1'b0, 32'h5F);
        retire();
        issue("sub", mk(ALU_SUB, 32'd5, 32'd7, 32'h0, 1'b0), 32'hFFFF_FFFE, 1'b0, 32'h40);
        retire();
        issue("slt", mk(ALU_SLT, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0), 32'h1, 1'b0, 32'h40);
        retire();
        issue("sltu", mk(ALU_SLTU, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0), 32'h0, 1'b0, 32'h40);
        retire();
        issue("sll_b40", mk(ALU_SLL, 32'h1, 32'h24, 32'h0, 1'b0), 32'h10, 1'b0, 32'h40);
        retire();
        issue("srl", mk(ALU_SRL, 32'hF000_0000, 32'd4, 32'h0, 1'b0), 32'h0F00_0000, 1'b0, 32'h40);
        retire();
        issue("xor", mk(ALU_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 1'b0), 32'hF0F0_F0F0, 1'b0, 32'h40);
        retire();
        issue("or", mk(ALU_OR, 32'hA0, 32'h0A, 32'h0, 1'b0), 32'hAA, 1'b0, 32'h40);
        retire();
        issue("and", mk(ALU_AND, 32'hF0F0, 32'h0FF0, 32'h0, 1'b0), 32'h00F0, 1'b0, 32'h40);
        retire();
        t = mk(ALU_ADD, 32'h0, 32'h0, 32'h8, 1'b1);
        t.asel = SRC_A_PC; t.rd = 5'd0;
        issue("auipc_x0", t, 32'h48, 1'b0, 32'h48);
        retire();

        // Branches and jumps
        t = mk(ALU_ADD, 32'hFFFF_FFFF, 32'h0, 32'h20, 1'b0);
        t.br = 1'b1; t.f3 = BR_BLT; t.pc = 32'h100; t.we = 1'b0;
        issue("blt", t, 32'hFFFF_FFFF, 1'b1, 32'h120);
        retire();
        t.f3 = BR_BLTU;
        issue("bltu", t, 32'hFFFF_FFFF, 1'b0, 32'h120);
        retire();
        t.f3 = 3'b010; t.rs2 = 32'hFFFF_FFFF;
        issue("br_bad_f3", t, 32'hFFFF_FFFE, 1'b0, 32'h120);
        retire();
        t = mk(ALU_ADD, 32'h1001, 32'h0, 32'h2, 1'b1);
        t.jalr = 1'b1; t.pc = 32'h200;
        issue("jalr", t, 32'h204, 1'b1, 32'h1002);
        retire();
        t = mk(ALU_ADD, 32'h0, 32'h0, 32'h10, 1'b1);
        t.jal = 1'b1; t.pc = 32'h300;
        issue("jal", t, 32'h304, 1'b1, 32'h310);
        retire();

        // Bubbles never jump, write or stall
        t.valid = 1'b0;
        issue("bubble_jal", t, 32'h304, 1'b0, 32'h310);
        retire();
        t = mk(ALU_ADD, 32'h3, 32'h4, 32'h0, 1'b0);
        t.valid = 1'b0; t.mul = 1'b1;
        cap(t);
        check("bubble_mul_busy", {31'b0, mul_busy}, 32'h0);
        @(negedge clk);
        check("bubble_mul_busy2", {31'b0, mul_busy}, 32'h0);

        // Multiplier
        t = mk(ALU_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b0);
        t.mul = 1'b1; t.mop = MUL_MULH;
        issue("mulh", t, 32'h4000_0000, 1'b0, 32'h40);
        wait_busy("mulh_busy_cycles", 33);
        retire();

        t.rs1 = 32'hFFFF_FFFF; t.rs2 = 32'hFFFF_FFFF; t.mop = MUL_MULHU;
        issue("mulhu", t, 32'hFFFF_FFFE, 1'b0, 32'h40);
        en_E = 1'b0;
        wait_busy("mulhu_busy_cycles", 33);
        retire();
        repeat (2) @(negedge clk);
        check("done_hold_res", result_E, 32'hFFFF_FFFE);
        check("done_hold_busy", {31'b0, mul_busy}, 32'h0);

        t.rs1 = 32'hFFFF_FFFD; t.rs2 = 32'h5; t.mop = MUL_MULHSU;
        issue("mulhsu", t, 32'hFFFF_FFFF, 1'b0, 32'h40);
        wait_busy("mulhsu_busy_cycles", 33);
        retire();

        // Flush mid-run aborts
        t.rs1 = 32'd7; t.rs2 = 32'd6; t.mop = MUL_MUL;
        issue("mul_abort", t, 32'h0, 1'b0, 32'h40);
        dropped = sb.pop_back();
        repeat (10) @(negedge clk);
        check("run_busy", {31'b0, mul_busy}, 32'h1);
        reset_E = 1'b1;
        #1;
        check("flush_result", result_E, 32'h0);
        check("flush_busy", {31'b0, mul_busy}, 32'h0);
        check("flush_valid", {31'b0, valid_E}, 32'h0);
        @(negedge clk);
        reset_E = 1'b0;
        @(negedge clk);
        check("post_flush_busy", {31'b0, mul_busy}, 32'h0);

        issue("mul_7x6", t, 32'd42, 1'b0, 32'h40);
        wait_busy("mul_busy_cycles", 33);
        retire();

        // Stall: D toggles but E holds
        t = mk(ALU_ADD, 32'h11, 32'hABCD, 32'h22, 1'b1);
        t.rd = 5'd9;
        issue("pre_stall", t, 32'h33, 1'b0, 32'h62);
        retire();
        en_E = 1'b0;
        for (int i = 0; i < 3; i++) begin
            t = mk(ALU_SUB, $urandom, $urandom, $urandom, 1'b0);
            t.jal = 1'b1; t.rd = 5'(i + 20);
            drive(t);
            en_E = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("stall_res", result_E, 32'h33);
            check("stall_rd", {27'b0, rd_E}, 32'd9);
            check("stall_store", store_data_E, 32'hABCD);
            check("stall_jump", {31'b0, jumping}, 32'h0);
        end
        en_E = 1'b1;
        valid_D = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
